tm_key_display_driver: RTL
==========================

# tm_key_display_driver

Parametrised keypad-to-display engine for the TM1638 board path, sitting between the board controller's decoded `keys` and its `digit`/`ledr`/`hgfedcba` inputs. It supports any digit, key and LED count, and debounces and edge-detects every key. Key presses edit a hex value register under one of four selectable edit modes. The block time-multiplexes that value onto a one-hot digit strobe with registered seven-segment patterns.

## Interface
- `w_digit`, 8, number of display digits (1..16); value register is 4*w_digit bits
- `w_key`, 8, number of keys (≥3)
- `w_led`, 8, number of LEDs
- `debounce_cyc`, 27000, consecutive stable cycles required to accept a key change (≥1)
- `scan_div`, 2700, clock cycles each digit stays selected (≥1)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, synchronous and active-high
- `key` in w_key: raw active-high key levels, asynchronous to `clk`
- `mode` in 2: edit mode, sampled every cycle
- `digit` out w_digit: one-hot active digit strobe
- `abcdefgh` out 8: segment pattern of active digit; bit 7 = a … bit 1 = g, bit 0 = h (dp), active-high
- `led` out w_led: LED levels
- `value` out 4*w_digit: current value register; nibble i is shown on digit i

## Operation
- Per key: 2-flop synchroniser; mismatch counter counts while synced ≠ debounced, clears when they are equal. When the count reaches `debounce_cyc`, the debounced level takes the synced level and the counter clears.
- Press: registered one-cycle pulse on each debounced 0→1. Releases generate no event.
- LEDs: `led[i]` toggles on press of key i for i < min(w_led, w_key). All other LED bits stay 0.
- Edits are applied on the edge after the press pulse, using `mode` sampled in the press-pulse cycle.
  - `mode`=00, per-digit: press of key i (i < w_digit) increments nibble i mod 16. Simultaneous presses all apply. Keys ≥ w_digit are ignored.
  - `mode`=01, counter: key0 adds 1 to the whole value, key1 subtracts 1, key2 clears it. Arithmetic is modulo 2^(4*w_digit). Priority on simultaneous presses: clear > increment > decrement. Other keys are ignored.
  - `mode`=10, shift: value shifts left one nibble, the MSB nibble is dropped, and nibble 0 takes the low 4 bits of the pressed key index. Simultaneous presses use only the lowest index.
  - `mode`=11, hold: value unchanged. LED toggling still occurs in every mode.
- Scan: counter counts 0..scan_div-1. On reaching scan_div-1, `digit` rotates one-hot toward the MSB, wrapping from bit w_digit-1 to bit 0.
- `abcdefgh` is registered every cycle from the nibble of the digit index `digit` will hold after that edge, so strobe and pattern always change on the same edge. `h` is always 0.
- Segment codes, 0..F: FC 60 DA F2 66 B6 BE E0 FE F6 EE 3E 9C 7A 9E 8E.

## Timing
- Reset values: `value`=0, `led`=0, `digit`=1 (bit 0), `abcdefgh`=8'hFC. All synchronisers, debounced levels, pulses and counters are 0.
- Press latency: raw key rises before edge n and is held. Debounced level rises at edge n+2+debounce_cyc, press pulse at n+3+debounce_cyc, and `value`/`led` update at n+4+debounce_cyc.
- A glitch shorter than `debounce_cyc` synced cycles produces no event.
- Value change to display: `abcdefgh` reflects a new nibble of the active digit one edge after `value` changes.
- Digit dwell: exactly `scan_div` cycles per digit. w_digit=1 keeps `digit`=1 permanently.
- `rst` asserted mid-debounce, mid-scan or with a pulse pending: the next edge forces reset values and the pending event is lost. A key still held after reset is re-debounced and produces one press.
- Counter mode wraps: all-F + 1 → 0, and 0 − 1 → all-F.

## Test plan
Configuration: w_digit=4, w_key=8, w_led=8, debounce_cyc=4, scan_div=3.
- Reset, then hold `key`=0 → `digit` sequence 1,2,4,8,1 with 3 cycles each; `abcdefgh`=FC throughout; `value`=0, `led`=0.
- Mode 00: press key1 and hold 20 cycles → `value`=16'h0010 exactly 8 edges after the raw rise; `led`=8'h02. Press key1 again → 16'h0020 and `led`=0.
- Mode 00: 2-cycle pulse on key0 → no change. Key0 bouncing 1,0,1 then stable → exactly one increment.
- Mode 01: press key1 from 0 → 16'hFFFF. Then key0 → 16'h0000. Then key0 and key2 together → 16'h0000 (clear wins).
- Mode 10: press key5, then key3, then key6 and key2 together → 16'h0532. Mode 11 press → value stays 16'h0532, LED still toggles. When digit 0 is active, `abcdefgh`=DA.
- `rst` asserted while key0 is mid-debounce → reset values on next edge. After release of `rst` with key0 still held, one increment follows debounce_cyc+4 edges later.

Source files
------------

// File: rtl/tm_key_display_driver.sv
// Keypad-to-display engine: debounces keys, edits a hex value register under four edit modes
// and scans that value onto a one-hot digit strobe with registered seven-segment patterns.
module tm_key_display_driver #(
    parameter int unsigned w_digit      = 8,
    parameter int unsigned w_key        = 8,
    parameter int unsigned w_led        = 8,
    parameter int unsigned debounce_cyc = 27000,
    parameter int unsigned scan_div     = 2700
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [w_key-1:0]       key,
    input  logic [1:0]             mode,
    output logic [w_digit-1:0]     digit,
    output logic [7:0]             abcdefgh,
    output logic [w_led-1:0]       led,
    output logic [4*w_digit-1:0]   value
);

    localparam int unsigned VW    = 4 * w_digit;
    localparam int unsigned CntW  = $clog2(debounce_cyc + 1);
    localparam int unsigned ScanW = (scan_div > 1) ? $clog2(scan_div) : 1;
    localparam int unsigned IdxW  = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int unsigned NEdit = (w_digit < w_key) ? w_digit : w_key;
    localparam int unsigned NLed  = (w_led < w_key) ? w_led : w_key;
    localparam logic [w_digit-1:0] DigitOne = w_digit'(1);

    logic [w_key-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, press_q;
    logic [CntW-1:0]  deb_cnt_q [w_key];
    logic [CntW-1:0]  deb_cnt_d [w_key];
    logic [VW-1:0]    value_q, value_d;
    logic [w_led-1:0] led_q, led_d;
    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       shift_sel;
    logic             scan_wrap;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 8'hFC;
            4'h1: seg_code = 8'h60;
            4'h2: seg_code = 8'hDA;
            4'h3: seg_code = 8'hF2;
            4'h4: seg_code = 8'h66;
            4'h5: seg_code = 8'hB6;
            4'h6: seg_code = 8'hBE;
            4'h7: seg_code = 8'hE0;
            4'h8: seg_code = 8'hFE;
            4'h9: seg_code = 8'hF6;
            4'hA: seg_code = 8'hEE;
            4'hB: seg_code = 8'h3E;
            4'hC: seg_code = 8'h9C;
            4'hD: seg_code = 8'h7A;
            4'hE: seg_code = 8'h9E;
            default: seg_code = 8'h8E;
        endcase
    endfunction

    // Counter runs only while the synced level disagrees with the accepted level.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < w_key; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == CntW'(debounce_cyc)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        value_d   = value_q;
        led_d     = led_q;
        shift_sel = '0;
        for (int i = NLed - 1; i >= 0; i--) begin
            led_d[i] = led_q[i] ^ press_q[i];
        end
        // Descending scan so the lowest pressed index is the one that sticks.
        for (int i = w_key - 1; i >= 0; i--) begin
            if (press_q[i]) shift_sel = 4'(i);
        end
        case (mode)
            2'b00: begin
                for (int i = 0; i < NEdit; i++) begin
                    if (press_q[i]) value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                end
            end
            2'b01: begin
                if (press_q[2])      value_d = '0;
                else if (press_q[0]) value_d = value_q + VW'(1);
                else if (press_q[1]) value_d = value_q - VW'(1);
            end
            2'b10: begin
                if (|press_q) value_d = (value_q << 4) | VW'(shift_sel);
            end
            default: value_d = value_q;
        endcase
    end

    // Pattern is fetched for the digit index that becomes active on this same edge.
    always_comb begin
        scan_wrap  = (scan_cnt_q == ScanW'(scan_div - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
        idx_d      = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IdxW'(w_digit - 1)) ? '0 : idx_q + IdxW'(1);
        end
        seg_d = seg_code(4'(value_q >> {idx_d, 2'b00}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            press_q    <= '0;
            value_q    <= '0;
            led_q      <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 8'hFC;
            for (int i = 0; i < w_key; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= key;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_q;
            press_q    <= deb_q & ~deb_dly_q;
            value_q    <= value_d;
            led_q      <= led_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            for (int i = 0; i < w_key; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign digit    = DigitOne << idx_q;
    assign abcdefgh = seg_q;
    assign led      = led_q;
    assign value    = value_q;

endmodule
